// File: rtl/bus_master_port_if.sv
// rtl/bus_master_port_if.sv - command and serial bus signals of one bus master port
//
// Groups the user command handshake, the serial master-side bus towards the
// arbiter and the done/error status pulses.
//   modport master : the port itself (drives cmd_ready, bus_*, done, error)
//   modport slave  : the user / arbiter side (drives cmd_*, bus_ready, bus_available)
interface bus_master_port_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_slave;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              bus_request;
  logic              bus_address_valid;
  logic              bus_address;
  logic              bus_data;
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_available;

  logic              done;
  logic              error;

  modport master (
    input  cmd_valid, cmd_slave, cmd_addr, cmd_data, bus_ready, bus_available,
    output cmd_ready, bus_request, bus_address_valid, bus_address, bus_data,
           bus_valid, done, error
  );

  modport slave (
    output cmd_valid, cmd_slave, cmd_addr, cmd_data, bus_ready, bus_available,
    input  cmd_ready, bus_request, bus_address_valid, bus_address, bus_data,
           bus_valid, done, error
  );
endinterface

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - serial bus master port: arbitrate, select slave, shift address and data
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high
//   bus    : bus_master_port_if.master (command handshake, serial bus, done/error)
// Parameters:
//   ADDR_W  : address bits shifted out MSB first
//   DATA_W  : data bits shifted out MSB first
//   TIMEOUT : consecutive bus_ready-low cycles in ADDR/DATA that abort a transfer
module bus_master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  bus_master_port_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SEL1, S_SEL2, S_CONN, S_ADDR, S_DATA, S_REL
  } state_t;

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [TO_W-1:0]   to_cnt, to_cnt_n;
  logic [1:0]        slave_q;
  // Address and data are kept as left-shifting registers so the MSB is
  // always the bit currently on the wire.
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q, done_n;
  logic              error_q, error_n;
  logic              load, shift_addr, shift_data;

  logic              cmd_ready_c, req_c, av_c, addr_c, data_c, valid_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      to_cnt  <= '0;
      slave_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      to_cnt  <= to_cnt_n;
      done_q  <= done_n;
      error_q <= error_n;
      if (load) begin
        slave_q <= bus.cmd_slave;
        addr_q  <= bus.cmd_addr;
        data_q  <= bus.cmd_data;
      end else begin
        if (shift_addr) addr_q <= {addr_q[ADDR_W-2:0], 1'b0};
        if (shift_data) data_q <= {data_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    to_cnt_n    = to_cnt;
    done_n      = 1'b0;
    error_n     = 1'b0;
    load        = 1'b0;
    shift_addr  = 1'b0;
    shift_data  = 1'b0;
    cmd_ready_c = 1'b0;
    req_c       = 1'b0;
    av_c        = 1'b0;
    addr_c      = 1'b0;
    data_c      = 1'b0;
    valid_c     = 1'b0;

    case (state)
      S_IDLE: begin
        // Held low during reset so nothing is offered before release.
        cmd_ready_c = !reset;
        if (bus.cmd_valid) begin
          load = 1'b1;
          // Slave 11 never reaches the bus: reject with an error pulse.
          if (bus.cmd_slave == 2'b11) error_n = 1'b1;
          else                        state_n = S_REQ;
        end
      end
      S_REQ: begin
        req_c = 1'b1;
        av_c  = 1'b1;
        if (bus.bus_available) state_n = S_SEL1;
      end
      S_SEL1: begin
        req_c  = 1'b1;
        addr_c = slave_q[1];
        // Losing the bus here means the other master won arbitration.
        state_n = bus.bus_available ? S_SEL2 : S_REQ;
      end
      S_SEL2: begin
        req_c   = 1'b1;
        addr_c  = slave_q[0];
        state_n = S_CONN;
      end
      S_CONN: begin
        req_c     = 1'b1;
        bit_cnt_n = '0;
        to_cnt_n  = '0;
        state_n   = S_ADDR;
      end
      S_ADDR: begin
        req_c   = 1'b1;
        valid_c = 1'b1;
        addr_c  = addr_q[ADDR_W-1];
        if (bus.bus_ready) begin
          to_cnt_n   = '0;
          shift_addr = 1'b1;
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt_n = '0;
            state_n   = S_DATA;
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end else if (to_cnt == TO_LAST) begin
          error_n = 1'b1;
          state_n = S_REL;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end
      S_DATA: begin
        req_c   = 1'b1;
        valid_c = 1'b1;
        data_c  = data_q[DATA_W-1];
        if (bus.bus_ready) begin
          to_cnt_n   = '0;
          shift_data = 1'b1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            done_n    = 1'b1;
            state_n   = S_REL;
          end else begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end
        end else if (to_cnt == TO_LAST) begin
          error_n = 1'b1;
          state_n = S_REL;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end
      S_REL: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready         = cmd_ready_c;
  assign bus.bus_request       = req_c;
  assign bus.bus_address_valid = av_c;
  assign bus.bus_address       = addr_c;
  assign bus.bus_data          = data_c;
  assign bus.bus_valid         = valid_c;
  assign bus.done              = done_q;
  assign bus.error             = error_q;

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - scoreboard testbench for bus_master_port
module tb_bus_master_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_master_port_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  bus_master_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic d;
    logic e;
    int   lat;       // -1: not checked
    bit   add_lows;  // add observed ready-low beats to lat
  } evt_t;

  evt_t       exp_evt[$];
  logic [1:0] exp_bits[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  int lows   = 0;
  bit mute   = 1'b0;
  int ready_mode = 0;
  evt_t       mon_ev;
  logic [1:0] mon_bit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // bus_ready driver: 0 = held 1, 1 = toggling, 2 = stuck 0
  initial begin
    bif.bus_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bif.bus_ready = 1'b1;
        1:       bif.bus_ready = ~bif.bus_ready;
        default: bif.bus_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expected beats/pulses whenever the DUT presents them.
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.cmd_valid && bif.cmd_ready) begin
        acc_cyc = cyc;
        lows    = 0;
      end
      if (bif.bus_valid && !bif.bus_ready) lows++;
      if (bif.bus_valid && bif.bus_ready && !mute) begin
        if (exp_bits.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          mon_bit = exp_bits.pop_front();
          chk("beat_addr_data", {bif.bus_address, bif.bus_data}, mon_bit);
        end
      end
      if (bif.done || bif.error) begin
        if (mute) chk("pulse_after_reset", {bif.done, bif.error}, 0);
        else if (exp_evt.size() == 0) chk("pulse_unexpected", {bif.done, bif.error}, 0);
        else begin
          mon_ev = exp_evt.pop_front();
          chk("pulse_kind", {bif.done, bif.error}, {mon_ev.d, mon_ev.e});
          if (mon_ev.lat >= 0)
            chk("latency", cyc - acc_cyc - 1, mon_ev.lat + (mon_ev.add_lows ? lows : 0));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_xfer(input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = AW - 1; i >= 0; i--) exp_bits.push_back({a[i], 1'b0});
    for (int i = DW - 1; i >= 0; i--) exp_bits.push_back({1'b0, d[i]});
  endtask

  task automatic push_evt(input logic d, input logic e, input int lat, input bit add);
    evt_t ev;
    ev.d = d; ev.e = e; ev.lat = lat; ev.add_lows = add;
    exp_evt.push_back(ev);
  endtask

  // Presents a command for one accepting edge, then scrambles the inputs.
  task automatic issue(input logic [1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bif.cmd_slave = s;
    bif.cmd_addr  = a;
    bif.cmd_data  = d;
    bif.cmd_valid = 1'b1;
    tick();
    bif.cmd_valid = 1'b0;
    bif.cmd_slave = ~s;
    bif.cmd_addr  = ~a;
    bif.cmd_data  = ~d;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!bif.cmd_ready && n < 300) begin
      tick();
      n++;
    end
    chk(name, bif.cmd_ready, 1);
  endtask

  typedef struct {
    logic [1:0]    s;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } vec_t;

  vec_t vecs[2];

  initial begin
    vecs[0] = '{s: 2'b00, a: 12'hFFF, d: 8'h00};
    vecs[1] = '{s: 2'b10, a: 12'h001, d: 8'hFF};

    bif.cmd_valid     = 1'b0;
    bif.cmd_slave     = 2'b00;
    bif.cmd_addr      = '0;
    bif.cmd_data      = '0;
    bif.bus_available = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("in_reset_outputs",
        {bif.cmd_ready, bif.bus_request, bif.bus_address_valid, bif.bus_address,
         bif.bus_data, bif.bus_valid, bif.done, bif.error}, 0);
    reset = 1'b0;
    tick();
    chk("after_reset_outputs",
        {bif.cmd_ready, bif.bus_request, bif.bus_address_valid, bif.bus_address,
         bif.bus_data, bif.bus_valid, bif.done, bif.error}, 8'h80);

    // Basic transfer: slave 01, addr A5C, data 3C
    push_xfer(12'hA5C, 8'h3C);
    push_evt(1'b1, 1'b0, 4 + AW + DW, 1'b0);
    issue(2'b01, 12'hA5C, 8'h3C);
    chk("req_phase", {bif.bus_request, bif.bus_address_valid, bif.cmd_ready}, 3'b110);
    tick();
    chk("sel1_phase", {bif.bus_request, bif.bus_address_valid, bif.bus_address}, 3'b100);
    tick();
    chk("sel2_phase", {bif.bus_request, bif.bus_address_valid, bif.bus_address}, 3'b101);
    tick();
    chk("conn_phase", {bif.bus_request, bif.bus_valid, bif.bus_address}, 3'b100);
    wait_idle("idle_after_basic");

    // Directed vector table
    foreach (vecs[i]) begin
      push_xfer(vecs[i].a, vecs[i].d);
      push_evt(1'b1, 1'b0, 4 + AW + DW, 1'b0);
      issue(vecs[i].s, vecs[i].a, vecs[i].d);
      wait_idle("idle_after_vector");
    end

    // bus_ready toggling: bits held until accepted, done delayed by low beats
    ready_mode = 1;
    push_xfer(12'h35A, 8'hC5);
    push_evt(1'b1, 1'b0, 4 + AW + DW, 1'b1);
    issue(2'b10, 12'h35A, 8'hC5);
    wait_idle("idle_after_toggle");
    ready_mode = 0;
    tick();

    // bus_available low for 5 REQ cycles
    bif.bus_available = 1'b0;
    push_xfer(12'h123, 8'h81);
    push_evt(1'b1, 1'b0, 4 + AW + DW + 4, 1'b0);
    issue(2'b01, 12'h123, 8'h81);
    for (int i = 0; i < 5; i++) begin
      chk("req_hold", {bif.bus_request, bif.bus_address_valid}, 2'b11);
      if (i < 4) tick();
    end
    bif.bus_available = 1'b1;
    wait_idle("idle_after_wait_avail");

    // Arbitration lost in SEL1
    push_xfer(12'h456, 8'h7E);
    push_evt(1'b1, 1'b0, 4 + AW + DW + 2, 1'b0);
    issue(2'b00, 12'h456, 8'h7E);
    tick();
    chk("sel1_before_loss", {bif.bus_request, bif.bus_address_valid}, 2'b10);
    bif.bus_available = 1'b0;
    tick();
    chk("req_after_loss", {bif.bus_request, bif.bus_address_valid}, 2'b11);
    bif.bus_available = 1'b1;
    wait_idle("idle_after_arb_loss");

    // Invalid slave 11: error next cycle, no bus activity
    push_evt(1'b0, 1'b1, 0, 1'b0);
    issue(2'b11, 12'h777, 8'h55);
    chk("slave11_cycle", {bif.bus_request, bif.bus_address_valid, bif.error, bif.cmd_ready}, 4'b0011);
    tick();
    chk("slave11_after", {bif.bus_request, bif.error, bif.done}, 3'b000);
    wait_idle("idle_after_slave11");

    // Timeout: bus_ready stuck low in ADDR
    ready_mode = 2;
    tick();
    push_evt(1'b0, 1'b1, 4 + TO, 1'b0);
    issue(2'b01, 12'h0F0, 8'hAA);
    wait_idle("idle_after_timeout");
    ready_mode = 0;
    tick();

    // Reset during DATA
    mute = 1'b1;
    issue(2'b10, 12'hABC, 8'h5A);
    repeat (18) tick();
    chk("in_data_before_reset", {bif.bus_request, bif.bus_valid, bif.bus_address}, 3'b110);
    reset = 1'b1;
    tick();
    chk("reset_mid_outputs",
        {bif.bus_request, bif.bus_address_valid, bif.bus_address, bif.bus_data,
         bif.bus_valid, bif.done, bif.error}, 0);
    reset = 1'b0;
    tick();
    chk("ready_after_mid_reset", {bif.cmd_ready, bif.done, bif.error}, 3'b100);
    repeat (2) tick();
    mute = 1'b0;

    chk("scoreboard_empty", exp_bits.size() + exp_evt.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule
